// File: rtl/dot_arb.sv
// Round-robin arbiter and sequencer for a shared two-stage cascaded dot-product datapath.
// Tracks in-flight ownership tags and stalls the whole datapath on response backpressure.
module dot_arb #(
  parameter int W          = 8,
  parameter int LATENCY    = 4,
  parameter int BIAS_DELAY = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [5*W-1:0] req0_data,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [5*W-1:0] req1_data,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp_data,
  output logic           dp_en,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  output logic [W-1:0]   dp_c,
  output logic [W-1:0]   dp_d,
  output logic [W-1:0]   dp_bias,
  input  logic [W-1:0]   dp_y
);

  logic           r_tag_vld [LATENCY];
  logic           r_tag_id  [LATENCY];
  logic [W-1:0]   r_bias    [BIAS_DELAY];
  logic           r_rr;

  logic           w_head_vld;
  logic           w_head_id;
  logic           w_stall;
  logic           w_en;
  logic           w_gnt_vld;
  logic           w_gnt_id;
  logic [5*W-1:0] w_tuple;

  assign w_head_vld = r_tag_vld[LATENCY-1];
  assign w_head_id  = r_tag_id[LATENCY-1];
  // Only the head's own response channel can hold the pipe; the other ready is ignored.
  assign w_stall    = w_head_vld && (w_head_id ? !rsp1_ready : !rsp0_ready);
  assign w_en       = reset && !w_stall;

  // Grant selection: a lone requester wins outright, contention follows the rr pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (w_en) begin
      if (req0_valid && req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_rr;
      end else if (req0_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b1;
      end else begin
        w_gnt_vld = 1'b0;
      end
    end else begin
      w_gnt_vld = 1'b0;
    end
  end

  // Operand mux of the granted tuple; bubbles drive zeros into the datapath.
  always_comb begin
    w_tuple = '0;
    if (w_gnt_vld) begin
      w_tuple = w_gnt_id ? req1_data : req0_data;
    end else begin
      w_tuple = '0;
    end
  end

  assign req0_ready = w_gnt_vld && !w_gnt_id;
  assign req1_ready = w_gnt_vld &&  w_gnt_id;
  assign dp_en      = w_en;
  assign dp_a       = w_tuple[4*W-1:3*W];
  assign dp_b       = w_tuple[3*W-1:2*W];
  assign dp_c       = w_tuple[2*W-1:W];
  assign dp_d       = w_tuple[W-1:0];
  assign dp_bias    = r_bias[BIAS_DELAY-1];
  assign rsp0_valid = w_head_vld && !w_head_id;
  assign rsp1_valid = w_head_vld &&  w_head_id;
  assign rsp_data   = dp_y;

  // Tag pipe, bias line and rr advance in lockstep with the datapath enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_id[i]  <= 1'b0;
      end
      for (int i = 0; i < BIAS_DELAY; i++) begin
        r_bias[i] <= '0;
      end
      r_rr <= 1'b0;
    end else if (w_en) begin
      r_tag_vld[0] <= w_gnt_vld;
      r_tag_id[0]  <= w_gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      r_bias[0] <= w_tuple[5*W-1:4*W];
      for (int i = 1; i < BIAS_DELAY; i++) begin
        r_bias[i] <= r_bias[i-1];
      end
      if (w_gnt_vld) begin
        r_rr <= ~w_gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_dot_arb.sv
// Directed self-checking bench for dot_arb with a behavioural model of the
// 4-stage cascaded datapath (A/B regs, product, +bias from C port, +c*d).
module tb_dot_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [39:0] req0_data = 40'd0, req1_data = 40'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        dp_en;
  logic [7:0]  dp_a, dp_b, dp_c, dp_d, dp_bias, dp_y;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dot_arb #(.W(8), .LATENCY(4), .BIAS_DELAY(2)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .dp_en(dp_en),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
    .dp_bias(dp_bias), .dp_y(dp_y)
  );

  // Datapath model: bias is read from the unregistered C port two enabled cycles after issue.
  logic [7:0] a1 = 8'd0, b1 = 8'd0, c1 = 8'd0, d1 = 8'd0, c2 = 8'd0, d2 = 8'd0;
  logic [7:0] m1 = 8'd0, m2 = 8'd0, p1 = 8'd0, y = 8'd0;
  always @(posedge clock) begin
    if (dp_en) begin
      a1 <= dp_a; b1 <= dp_b; c1 <= dp_c; d1 <= dp_d;
      m1 <= a1 * b1; c2 <= c1; d2 <= d1;
      p1 <= m1 + dp_bias; m2 <= c2 * d2;
      y  <= p1 + m2;
    end
  end
  assign dp_y = y;

  function automatic logic [39:0] tup(input logic [7:0] bias, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    return {bias, a, b, c, d};
  endfunction

  task automatic test_reset();
    req0_valid = 1'b1; req0_data = tup(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    @(negedge clock); #1;
    n_cmp++; if (dp_en !== 1'b0) begin n_err++; $display("FAIL reset_dp_en: got %b want 0", dp_en); end
    n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
    n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp0_valid, rsp1_valid}); end
    n_cmp++; if (dp_a !== 8'd0) begin n_err++; $display("FAIL reset_dp_a: got %h want 00", dp_a); end
    @(negedge clock);
    req0_valid = 1'b0; reset = 1'b1;
    @(negedge clock); #1;
    n_cmp++; if (dp_en !== 1'b1) begin n_err++; $display("FAIL post_reset_dp_en: got %b want 1", dp_en); end
  endtask

  task automatic test_contention();
    logic [39:0] t0 [3];
    logic [39:0] t1 [3];
    logic [7:0]  ex [6];
    int n0 = 0, n1 = 0;
    t0[0] = tup(8'd0, 8'd1, 8'd2, 8'd3, 8'd4);      // 14
    t0[1] = tup(8'd5, 8'd2, 8'd2, 8'd1, 8'd1);      // 10
    t0[2] = tup(8'hFF, 8'd10, 8'd10, 8'd0, 8'd0);   // 99
    t1[0] = tup(8'd0, 8'd5, 8'd5, 8'd0, 8'd0);      // 25
    t1[1] = tup(8'd1, 8'hFE, 8'd3, 8'd0, 8'd0);     // -5
    t1[2] = tup(8'd100, 8'd10, 8'd10, 8'd10, 8'd10);// 300 mod 256
    ex[0] = 8'd14; ex[1] = 8'd25; ex[2] = 8'd10; ex[3] = 8'hFB; ex[4] = 8'd99; ex[5] = 8'd44;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      req0_valid = (k < 6); req1_valid = (k < 6);
      req0_data = t0[n0 % 3]; req1_data = t1[n1 % 3];
      #1;
      if (k < 6) begin
        n_cmp++; if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_err++; $display("FAIL cont_grant k=%0d: got r1r0=%b want %b", k, {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10); end
        if (k % 2 == 0) n0++; else n1++;
      end
      if (k >= 4 && k < 10) begin
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_err++; $display("FAIL cont_rsp_vld k=%0d: got %b want %b", k, {rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 2'b01 : 2'b10); end
        n_cmp++; if (rsp_data !== ex[k-4]) begin n_err++; $display("FAIL cont_rsp_data k=%0d: got %h want %h", k, rsp_data, ex[k-4]); end
      end else begin
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_err++; $display("FAIL cont_idle k=%0d: got %b want 00", k, {rsp1_valid, rsp0_valid}); end
      end
    end
  endtask

  task automatic test_single();
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      req0_valid = (k == 0); req0_data = tup(8'd1, 8'd3, 8'd4, 8'd2, 8'd5);
      #1;
      n_cmp++; if (req0_ready !== (k == 0)) begin n_err++; $display("FAIL single_ready k=%0d: got %b want %b", k, req0_ready, (k == 0)); end
      n_cmp++; if (rsp0_valid !== (k == 4)) begin n_err++; $display("FAIL single_rsp0 k=%0d: got %b want %b", k, rsp0_valid, (k == 4)); end
      n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp1 k=%0d: got %b want 0", k, rsp1_valid); end
      if (k == 4) begin
        n_cmp++; if (rsp_data !== 8'h17) begin n_err++; $display("FAIL single_data: got %h want 17", rsp_data); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] t [3];
    logic [7:0]  ex [3];
    t[0] = tup(8'd7, 8'd3, 8'd3, 8'd0, 8'd0);   ex[0] = 8'd16;
    t[1] = tup(8'd0, 8'hFD, 8'd4, 8'd1, 8'd1);  ex[1] = 8'hF5;
    t[2] = tup(8'd2, 8'd0, 8'd0, 8'd6, 8'd7);   ex[2] = 8'd44;
    rsp0_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      rsp0_ready = (k >= 9);
      req0_valid = (k < 3) || (k >= 4 && k < 9);
      req1_valid = (k >= 4 && k < 9);
      req0_data = (k < 3) ? t[k] : tup(8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
      req1_data = tup(8'd8, 8'd8, 8'd8, 8'd8, 8'd8);
      #1;
      if (k < 3) begin
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_issue k=%0d: got %b want 1", k, req0_ready); end
      end else if (k < 9 && k >= 4) begin
        n_cmp++; if (dp_en !== 1'b0) begin n_err++; $display("FAIL bp_dp_en k=%0d: got %b want 0", k, dp_en); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready k=%0d: got %b want 00", k, {req0_ready, req1_ready}); end
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp_data !== ex[0]) begin n_err++; $display("FAIL bp_hold k=%0d: got %b/%h want 1/%h", k, rsp0_valid, rsp_data, ex[0]); end
        n_cmp++; if ({dp_a, dp_b, dp_c, dp_d} !== 32'd0) begin n_err++; $display("FAIL bp_ops k=%0d: got %h want 0", k, {dp_a, dp_b, dp_c, dp_d}); end
      end else if (k >= 9 && k < 12) begin
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp_data !== ex[k-9]) begin n_err++; $display("FAIL bp_drain k=%0d: got %b/%h want 1/%h", k, rsp0_valid, rsp_data, ex[k-9]); end
      end else if (k == 12) begin
        n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL bp_empty: got %b want 00", {rsp0_valid, rsp1_valid}); end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_signed_wrap();
    logic [39:0] t [3];
    logic [7:0]  ex [3];
    t[0] = tup(8'd0, 8'h80, 8'h80, 8'd0, 8'd0);  ex[0] = 8'h00;
    t[1] = tup(8'd1, 8'h7F, 8'd2, 8'd0, 8'd0);   ex[1] = 8'hFF;
    t[2] = tup(8'd0, 8'hFF, 8'd1, 8'hFF, 8'd1);  ex[2] = 8'hFE;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      req1_valid = (k < 3); req1_data = t[k % 3];
      #1;
      if (k >= 4 && k < 7) begin
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp_data !== ex[k-4]) begin n_err++; $display("FAIL wrap k=%0d: got %b/%h want 1/%h", k, rsp1_valid, rsp_data, ex[k-4]); end
      end
    end
  endtask

  task automatic test_bias_align();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      req0_valid = (k < 3); req0_data = tup(8'(10 * (k + 1)), 8'd0, 8'd0, 8'd0, 8'd0);
      #1;
      if (k >= 4 && k < 7) begin
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp_data !== 8'(10 * (k - 3))) begin
          n_err++; $display("FAIL bias k=%0d: got %b/%0d want 1/%0d", k, rsp0_valid, rsp_data, 10 * (k - 3)); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      req0_valid = (k < 3); req0_data = tup(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
      #1;
    end
    n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %b want 1", rsp0_valid); end
    reset = 1'b0; #1;
    n_cmp++; if ({rsp0_valid, rsp1_valid, dp_en} !== 3'b000) begin n_err++; $display("FAIL mid_drop: got %b want 000", {rsp0_valid, rsp1_valid, dp_en}); end
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock); #1;
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL mid_quiet k=%0d: got %b want 00", k, {rsp0_valid, rsp1_valid}); end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      req1_valid = (k == 0); req1_data = tup(8'd3, 8'd2, 8'd4, 8'd1, 8'd1);
      #1;
      if (k == 0) begin
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL mid_new_ready: got %b want 1", req1_ready); end
      end
      n_cmp++; if ({rsp1_valid, rsp0_valid} !== ((k == 4) ? 2'b10 : 2'b00)) begin
        n_err++; $display("FAIL mid_new_vld k=%0d: got %b want %b", k, {rsp1_valid, rsp0_valid}, (k == 4) ? 2'b10 : 2'b00); end
      if (k == 4) begin
        n_cmp++; if (rsp_data !== 8'd12) begin n_err++; $display("FAIL mid_new_data: got %0d want 12", rsp_data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_signed_wrap();
    test_bias_align();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dot_arb.md
Name: dot_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared two-stage cascaded 8-bit dot-product datapath, which computes y = a*b + bias + c*d.
- Accepts operand tuples over valid/ready, issues at most one tuple per cycle into the datapath, and drives the datapath clock enable.
- Delays bias to line up with the product stage, and tracks in-flight ownership tags so each result returns to the requester that issued it.
- Backpressure on either response stalls the whole datapath through its enable, so no result is ever dropped.

Parameters:
- W, 8, operand and result width.
- LATENCY, 4, enabled cycles from issue to valid y at the datapath output.
- BIAS_DELAY, 2, enabled cycles between issue and bias consumption (datapath C port is unregistered).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req0_valid  in  1  requester 0 has a tuple.
- req0_ready  out  1  requester 0 tuple accepted this cycle.
- req0_data  in  5*W  {bias, a, b, c, d}, signed.
- req1_valid  in  1  requester 1 has a tuple.
- req1_ready  out  1  requester 1 tuple accepted this cycle.
- req1_data  in  5*W  as req0_data.
- rsp0_valid  out  1  result for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid  out  1  result for requester 1.
- rsp1_ready  in  1  requester 1 takes the result.
- rsp_data  out  W  result, shared by both response channels.
- dp_en  out  1  datapath clock enable (all CE pins).
- dp_a, dp_b, dp_c, dp_d  out  W each  operands for the datapath A/B registers.
- dp_bias  out  W  bias for the datapath C port.
- dp_y  in  W  datapath result.

Behaviour:
- State:
  - tag pipe of LATENCY entries {vld, id}.
  - bias delay line of BIAS_DELAY W-bit entries.
  - round-robin pointer rr (1 bit).
- Reset (reset low, asynchronous):
  - tag pipe vld all 0, bias line all 0, rr=0.
  - While reset is low: dp_en=0, req*_ready=0, rsp*_valid=0, dp_* operands=0.
  - Normal operation starts on the first clock edge after reset goes high.
- Head of pipe is the last tag entry, called head:
  - rspN_valid = head.vld && head.id==N.
  - rsp_data = dp_y, passed through combinationally.
- Stall:
  - stall = head.vld && !rsp[head.id]_ready.
  - dp_en = !stall.
  - When stall=1: tag pipe, bias line and rr hold; req*_ready=0.
- Issue, only when dp_en=1:
  - Only one valid request: grant it.
  - Both valid: grant requester rr, then set rr to the other requester.
  - On a grant: rr becomes 1-granted.
  - reqN_ready=1 for the granted requester only; no grant means both readys are 0.
  - The handshake completes in the same cycle.
- Operand drive:
  - dp_a/b/c/d are a combinational mux of the granted tuple; 0 when there is no grant.
  - The datapath registers them on dp_en.
- Bias:
  - The granted bias, or 0 when there is no grant, enters the bias line on dp_en.
  - dp_bias = last entry of the bias line.
  - The line shifts only on dp_en.
- Tag pipe:
  - On dp_en, shift in {granted, id}; bubbles enter with vld=0.
  - The head retires when dp_en=1 (its response handshake completes that cycle).
  - A new issue and a retirement in the same cycle are legal: throughput is 1 per cycle.
- Ordering: results return in issue order; each requester sees its own results in order.
- Arithmetic is done by the datapath, not this block. The reference model is y = (a*b + bias + c*d) mod 2^W, all operands signed two's complement; rsp_data is the low W bits.
- Simultaneous events:
  - A stall while both requesters are valid means no grant and rr unchanged.
  - A response ready for the non-head id is ignored.
- Reset mid-operation: all in-flight tags are discarded. No response is produced for tuples accepted before reset, even if dp_y later shows stale data.
- Liveness: with both requesters continuously valid and responses always ready, neither requester waits more than 1 cycle between grants.

Test Plan:
- Single issue: req0 bias=1, a=3, b=4, c=2, d=5, rsp ready=1 -> req0_ready=1 for 1 cycle; rsp0_valid exactly 4 cycles later with rsp_data=23 (0x17); rsp1_valid stays 0.
- Contention: both valid for 6 cycles with distinct tuples -> grants 0,1,0,1,0,1; responses come back in the same interleave and each rsp_data matches its model.
- Backpressure: 3 req0 tuples in flight, rsp0_ready=0 when the first reaches head -> dp_en=0, both readys 0, rsp0_valid held, dp_* stable. Raise rsp0_ready after 5 cycles -> 3 results in order, no loss or duplication.
- Signed wrap:
  - a=b=-128, c=d=0, bias=0 -> rsp_data=0x00.
  - a=127, b=2, bias=1, c=d=0 -> 0xFF.
  - a=-1, b=1, c=-1, d=1, bias=0 -> 0xFE.
- Bias alignment: back-to-back issues with bias 10, 20, 30 and all products 0 -> results 10, 20, 30, with no bias from a neighbouring issue mixed in.
- Reset mid-flight: 3 tuples outstanding, pulse reset low for 2 cycles -> rsp*_valid fall immediately; no responses for 10 cycles after release; then a new req1 tuple completes normally.
